baud_frac_generator: RTL and testbench
======================================

Name: baud_frac_generator

Overview:
- Parametrised successor to the integer baud divider: fractional divide with oversampling.
- Produces the RX oversample strobe (os_tick), the mid-bit sample strobe (mid_tick) and the TX bit strobe (bit_tick) from one divisor programmed at runtime.
- A fractional accumulator lets standard baud rates be hit from arbitrary system clocks.
- Sits between the UART config registers and the uart_tx/uart_rx FSMs. sync re-phases it on an RX start-bit edge.

Parameters:
- INT_BITS, 16: width of the integer divisor. Period term is div_int+1 clocks.
- FRAC_BITS, 4: width of the fractional divisor, in units of 1/2^FRAC_BITS clock.
- OVERSAMPLE, 16: os_ticks per bit. Must be 2 or more.
- OVS_W, $clog2(OVERSAMPLE): width of os_phase.

Ports:
- clk, input, 1: rising-edge clock.
- reset, input, 1: synchronous, active-low reset. Clears all state on the clock edge where it is sampled low.
- en, input, 1: run enable. Low holds all counters cleared.
- sync, input, 1: phase restart pulse.
- div_int, input, INT_BITS: integer divisor.
- div_frac, input, FRAC_BITS: fractional divisor.
- os_tick, output, 1: one-cycle oversample strobe.
- mid_tick, output, 1: one-cycle strobe on os_phase OVERSAMPLE/2-1.
- bit_tick, output, 1: one-cycle strobe on os_phase OVERSAMPLE-1.
- os_phase, output, OVS_W: current oversample index.

Behaviour:
- Reset (reset==0 at posedge):
  - cnt, frac_acc, ext, os_phase set to 0.
  - os_tick, mid_tick, bit_tick set to 0.
  - Shadow divisors load from div_int/div_frac.
  - Takes effect even mid-period.
- Registers:
  - cnt: INT_BITS+1 wide.
  - frac_acc: FRAC_BITS wide.
  - ext: 1 bit.
  - div_int_s, div_frac_s: shadow copies of the divisor.
  - All outputs are registered.
- en==0:
  - Same clearing as reset.
  - Shadows track the inputs every cycle.
  - Strobes are 0 from the next edge.
- Terminal value: T = div_int_s + ext, computed INT_BITS+1 wide so there is no overflow at the max divisor.
- Each edge with en==1, priority order:
  - 1. sync==1:
    - cnt, frac_acc, ext, os_phase set to 0.
    - Strobes set to 0.
    - Shadows reload from the inputs.
  - 2. cnt==T (terminal):
    - cnt set to 0.
    - {carry, frac_acc} set to frac_acc + div_frac_s.
    - ext set to carry.
    - Shadows reload from the inputs.
    - os_tick set to 1.
    - If os_phase==OVERSAMPLE/2-1: mid_tick set to 1.
    - If os_phase==OVERSAMPLE-1: bit_tick set to 1 and os_phase wraps to 0; otherwise os_phase increments.
  - 3. Otherwise: cnt increments and all strobes set to 0.
- Timing:
  - From cleared state, the first os_tick is high after div_int+1 enabled edges.
  - Average os_tick period is div_int + 1 + div_frac/2^FRAC_BITS clocks.
  - Each individual period is div_int+1 or div_int+2 clocks.
  - bit_tick and mid_tick are coincident with an os_tick.
  - os_phase advances on the same edge that os_tick rises.
- Divisor changes apply only at a period boundary, sync, or while en==0. A period in progress never stretches or truncates.
- Boundary cases:
  - div_int==0 with div_frac==0: os_tick held high continuously.
  - div_int==0 with div_frac!=0: periods of 1 or 2 clocks.
  - sync on a terminal edge: sync wins and no strobe fires.
  - sync held high: the block stays cleared.
  - en falling mid-period: the period is abandoned with no strobe.
  - OVERSAMPLE==2: mid_tick on os_phase 0, bit_tick on os_phase 1.

Decomposition:
- Shared UART package/header holds:
  - Default constants UART_OVERSAMPLE=16, UART_DIV_INT_BITS=16, UART_DIV_FRAC_BITS=4.
  - The divisor field widths used by the config register block.
- Sub-module baud_frac_divider contains cnt, frac_acc, ext, shadows and sync/en handling. It outputs a raw os_tick.
- The top level adds the os_phase counter and the mid_tick/bit_tick decode.

Test Plan:
- Reset mid-run:
  - Stimulus: div_int=9, div_frac=0, run 25 cycles, then reset=0 for 3 edges.
  - Required: all outputs 0 and os_phase=0 on the first reset edge; first os_tick 10 edges after release.
- Integer divide:
  - Stimulus: div_int=9, div_frac=0, OVERSAMPLE=16.
  - Required: os_tick every 10 clocks; mid_tick on every 8th os_tick (os_phase 7); bit_tick every 160 clocks on os_phase 15.
- Fractional divide (100 MHz to 115200x16):
  - Stimulus: div_int=53, div_frac=4.
  - Required: first four intervals 54, then repeating 55,54,54,54; 64 os_ticks in exactly 3472 clocks after the first tick.
- Divisor change mid-period:
  - Stimulus: div_int 9 to 4 when cnt=3.
  - Required: current interval completes at 10 clocks, following intervals are 5.
- Sync re-phase:
  - Stimulus: div_int=9, sync pulsed at os_phase=5, cnt=6.
  - Required: no strobe on that edge, os_phase=0, next os_tick 10 edges later.
  - Stimulus: sync on a terminal edge.
  - Required: os_tick suppressed.
- Edge divisors:
  - Stimulus: div_int=0, div_frac=0.
  - Required: os_tick constantly 1.
  - Stimulus: div_int=0, div_frac=8.
  - Required: intervals alternate 1,2.
  - Stimulus: en=0.
  - Required: all strobes 0 from the next edge.

Source files
------------

// File: rtl/baud_frac_generator_pkg.sv
// Shared UART divisor constants and the config-register divisor field layout.
package baud_frac_generator_pkg;

    localparam int UART_OVERSAMPLE    = 16;
    localparam int UART_DIV_INT_BITS  = 16;
    localparam int UART_DIV_FRAC_BITS = 4;
    localparam int UART_DIV_W         = UART_DIV_INT_BITS + UART_DIV_FRAC_BITS;

    // Divisor register field layout as seen by the config register block.
    typedef struct packed {
        logic [UART_DIV_INT_BITS-1:0]  div_int;
        logic [UART_DIV_FRAC_BITS-1:0] div_frac;
    } uart_div_t;

    function automatic int ovs_phase_w(input int oversample);
        return (oversample < 2) ? 1 : $clog2(oversample);
    endfunction

endpackage

// File: rtl/baud_frac_if.sv
// Divisor/control inputs and baud strobes between the UART config block and the generator.
interface baud_frac_if
    import baud_frac_generator_pkg::*;
#(
    parameter int INT_BITS  = UART_DIV_INT_BITS,
    parameter int FRAC_BITS = UART_DIV_FRAC_BITS,
    parameter int OVS_W     = ovs_phase_w(UART_OVERSAMPLE)
);
    logic                 en;
    logic                 sync;
    logic [INT_BITS-1:0]  div_int;
    logic [FRAC_BITS-1:0] div_frac;
    logic                 os_tick;
    logic                 mid_tick;
    logic                 bit_tick;
    logic [OVS_W-1:0]     os_phase;

    modport master (
        output en, sync, div_int, div_frac,
        input  os_tick, mid_tick, bit_tick, os_phase
    );

    modport slave (
        input  en, sync, div_int, div_frac,
        output os_tick, mid_tick, bit_tick, os_phase
    );
endinterface

// File: rtl/baud_frac_divider.sv
// Purpose: fractional clock divider producing the raw oversample strobe.
// Latency: os_tick registered, first strobe div_int+1 enabled edges after clear.
// Backpressure: none; strobes are free-running and must be consumed when high.
module baud_frac_divider
    import baud_frac_generator_pkg::*;
#(
    parameter int INT_BITS  = UART_DIV_INT_BITS,
    parameter int FRAC_BITS = UART_DIV_FRAC_BITS
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 en,
    input  logic                 sync,
    input  logic [INT_BITS-1:0]  div_int,
    input  logic [FRAC_BITS-1:0] div_frac,
    output logic                 os_tick,
    output logic                 advance
);

    localparam logic [INT_BITS:0] CNT_ONE = {{INT_BITS{1'b0}}, 1'b1};

    logic [INT_BITS:0]    cnt;
    logic [INT_BITS:0]    terminal;
    logic [FRAC_BITS-1:0] frac_acc;
    logic [FRAC_BITS:0]   frac_sum;
    logic                 ext;
    logic [INT_BITS-1:0]  div_int_s;
    logic [FRAC_BITS-1:0] div_frac_s;
    logic                 clear;
    logic                 at_term;

    // One bit wider than the divisor so div_int_s = all-ones plus ext cannot wrap.
    assign terminal = {1'b0, div_int_s} + {{INT_BITS{1'b0}}, ext};
    assign frac_sum = {1'b0, frac_acc} + {1'b0, div_frac_s};
    assign clear    = !reset || !en || sync;
    assign at_term  = (cnt == terminal);
    assign advance  = !clear && at_term;

    always_ff @(posedge clk) begin
        if (clear) begin
            cnt        <= '0;
            frac_acc   <= '0;
            ext        <= 1'b0;
            div_int_s  <= div_int;
            div_frac_s <= div_frac;
            os_tick    <= 1'b0;
        end else if (at_term) begin
            // The carry out of the fraction stretches the next period by one clock.
            cnt               <= '0;
            {ext, frac_acc}   <= frac_sum;
            div_int_s         <= div_int;
            div_frac_s        <= div_frac;
            os_tick           <= 1'b1;
        end else begin
            cnt     <= cnt + CNT_ONE;
            os_tick <= 1'b0;
        end
    end

endmodule

// File: rtl/baud_frac_generator.sv
// Purpose: UART baud strobes (oversample, mid-bit, bit) from a fractional divisor.
// Latency: all strobes registered and coincident; first os_tick div_int+1 edges after clear.
// Backpressure: none; sync re-phases, en low holds everything cleared.
module baud_frac_generator
    import baud_frac_generator_pkg::*;
#(
    parameter int INT_BITS   = UART_DIV_INT_BITS,
    parameter int FRAC_BITS  = UART_DIV_FRAC_BITS,
    parameter int OVERSAMPLE = UART_OVERSAMPLE,
    parameter int OVS_W      = ovs_phase_w(OVERSAMPLE)
) (
    input  logic      clk,
    input  logic      reset,
    baud_frac_if.slave bus
);

    localparam int               MID_IDX    = OVERSAMPLE / 2 - 1;
    localparam int               LAST_IDX   = OVERSAMPLE - 1;
    localparam logic [OVS_W-1:0] MID_PHASE  = OVS_W'(MID_IDX);
    localparam logic [OVS_W-1:0] LAST_PHASE = OVS_W'(LAST_IDX);
    localparam logic [OVS_W-1:0] PHASE_ONE  = OVS_W'(1);

    logic             os_tick_raw;
    logic             advance;
    logic [OVS_W-1:0] os_phase_q;
    logic             mid_tick_q;
    logic             bit_tick_q;
    logic             at_mid;
    logic             at_last;

    baud_frac_divider #(
        .INT_BITS  (INT_BITS),
        .FRAC_BITS (FRAC_BITS)
    ) u_divider (
        .clk      (clk),
        .reset    (reset),
        .en       (bus.en),
        .sync     (bus.sync),
        .div_int  (bus.div_int),
        .div_frac (bus.div_frac),
        .os_tick  (os_tick_raw),
        .advance  (advance)
    );

    assign at_mid  = (os_phase_q == MID_PHASE);
    assign at_last = (os_phase_q == LAST_PHASE);

    // Phase decode uses the pre-advance index so mid/bit land on the same edge as os_tick.
    always_ff @(posedge clk) begin
        if (!reset || !bus.en || bus.sync) begin
            os_phase_q <= '0;
            mid_tick_q <= 1'b0;
            bit_tick_q <= 1'b0;
        end else if (advance) begin
            mid_tick_q <= at_mid;
            bit_tick_q <= at_last;
            os_phase_q <= at_last ? '0 : os_phase_q + PHASE_ONE;
        end else begin
            mid_tick_q <= 1'b0;
            bit_tick_q <= 1'b0;
        end
    end

    assign bus.os_tick  = os_tick_raw;
    assign bus.mid_tick = mid_tick_q;
    assign bus.bit_tick = bit_tick_q;
    assign bus.os_phase = os_phase_q;

endmodule

// File: tb/tb_baud_frac_generator.sv
// Self-checking bench for baud_frac_generator: directed scenarios plus randomized model compare.
module tb_baud_frac_generator;
    import baud_frac_generator_pkg::*;

    localparam int IB  = 16;
    localparam int FB  = 4;
    localparam int OVS = 16;
    localparam int FONE = 1 << FB;

    logic clk;
    logic reset;
    int   checks;
    int   errors;
    int   cyc;

    baud_frac_if #(.INT_BITS(IB), .FRAC_BITS(FB), .OVS_W(4)) bus ();
    baud_frac_if #(.INT_BITS(IB), .FRAC_BITS(FB), .OVS_W(1)) bus2 ();

    assign bus2.en       = bus.en;
    assign bus2.sync     = bus.sync;
    assign bus2.div_int  = bus.div_int;
    assign bus2.div_frac = bus.div_frac;

    baud_frac_generator #(.INT_BITS(IB), .FRAC_BITS(FB), .OVERSAMPLE(OVS), .OVS_W(4)) u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    baud_frac_generator #(.INT_BITS(IB), .FRAC_BITS(FB), .OVERSAMPLE(2), .OVS_W(1)) u_dut2 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus2)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference model: each period's length is decided when it starts, from the
    // divisor then in force plus one extra clock whenever the running fraction overflows.
    int m_elapsed, m_len, m_acc, m_f, m_phase, m_phase2;
    logic exp_os, exp_mid, exp_bt, exp_mid2, exp_bt2;

    task automatic edge_step();
        int tot;
        @(posedge clk);
        if (!reset || !bus.en || bus.sync) begin
            m_elapsed = 0;
            m_len     = int'(bus.div_int) + 1;
            m_acc     = 0;
            m_f       = int'(bus.div_frac);
            m_phase   = 0;
            m_phase2  = 0;
            exp_os = 0; exp_mid = 0; exp_bt = 0; exp_mid2 = 0; exp_bt2 = 0;
        end else begin
            m_elapsed++;
            if (m_elapsed == m_len) begin
                exp_os   = 1;
                exp_mid  = (m_phase == OVS / 2 - 1);
                exp_bt   = (m_phase == OVS - 1);
                exp_mid2 = (m_phase2 == 0);
                exp_bt2  = (m_phase2 == 1);
                m_phase  = (m_phase + 1) % OVS;
                m_phase2 = (m_phase2 + 1) % 2;
                tot       = m_acc + m_f;
                m_len     = int'(bus.div_int) + 1 + ((tot >= FONE) ? 1 : 0);
                m_acc     = tot % FONE;
                m_f       = int'(bus.div_frac);
                m_elapsed = 0;
            end else begin
                exp_os = 0; exp_mid = 0; exp_bt = 0; exp_mid2 = 0; exp_bt2 = 0;
            end
        end
        cyc++;
        #1;
    endtask

    task automatic drive(input logic e, input logic s, input int di, input int df);
        bus.en       = e;
        bus.sync     = s;
        bus.div_int  = IB'(di);
        bus.div_frac = FB'(df);
    endtask

    task automatic clear_run(input int di, input int df);
        drive(1'b0, 1'b0, di, df);
        edge_step();
        bus.en = 1'b1;
    endtask

    task automatic test_reset();
        int first;
        reset = 1'b0;
        drive(1'b1, 1'b0, 9, 0);
        repeat (2) edge_step();
        checks++;
        if ({bus.os_tick, bus.mid_tick, bus.bit_tick} !== 3'b000 || bus.os_phase !== 4'd0) begin
            errors++;
            $display("FAIL reset_initial: strobes=%b phase=%0d, want 000 phase 0",
                     {bus.os_tick, bus.mid_tick, bus.bit_tick}, bus.os_phase);
        end
        reset = 1'b1;
        repeat (25) edge_step();
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            edge_step();
            checks++;
            if ({bus.os_tick, bus.mid_tick, bus.bit_tick} !== 3'b000 || bus.os_phase !== 4'd0) begin
                errors++;
                $display("FAIL reset_midrun[%0d]: strobes=%b phase=%0d, want 000 phase 0",
                         i, {bus.os_tick, bus.mid_tick, bus.bit_tick}, bus.os_phase);
            end
        end
        reset = 1'b1;
        first = -1;
        for (int i = 1; i <= 40 && first < 0; i++) begin
            edge_step();
            if (bus.os_tick === 1'b1) first = i;
        end
        checks++;
        if (first !== 10) begin
            errors++;
            $display("FAIL reset_first_tick: got %0d edges, want 10", first);
        end
    endtask

    task automatic test_integer();
        clear_run(9, 0);
        for (int i = 1; i <= 400; i++) begin
            edge_step();
            checks++;
            if (bus.os_tick !== ((i % 10) == 0)) begin
                errors++;
                $display("FAIL int_os_tick@%0d: got %b want %b", i, bus.os_tick, (i % 10) == 0);
            end
            checks++;
            if (bus.mid_tick !== ((i % 160) == 80)) begin
                errors++;
                $display("FAIL int_mid_tick@%0d: got %b want %b", i, bus.mid_tick, (i % 160) == 80);
            end
            checks++;
            if (bus.bit_tick !== ((i % 160) == 0)) begin
                errors++;
                $display("FAIL int_bit_tick@%0d: got %b want %b", i, bus.bit_tick, (i % 160) == 0);
            end
            checks++;
            if (bus.os_phase !== 4'((i / 10) % 16)) begin
                errors++;
                $display("FAIL int_phase@%0d: got %0d want %0d", i, bus.os_phase, (i / 10) % 16);
            end
        end
    endtask

    task automatic test_fractional();
        int t[$];
        int want;
        clear_run(53, 4);
        for (int i = 1; i <= 4000 && t.size() < 65; i++) begin
            edge_step();
            if (bus.os_tick === 1'b1) t.push_back(i);
        end
        checks++;
        if (t.size() < 65) begin
            errors++;
            $display("FAIL frac_tick_count: got %0d ticks, want 65", t.size());
        end else begin
            for (int k = 0; k < 12; k++) begin
                want = (k < 4) ? 54 : (((k - 4) % 4 == 0) ? 55 : 54);
                checks++;
                if (((k == 0) ? t[0] : t[k] - t[k-1]) !== want) begin
                    errors++;
                    $display("FAIL frac_interval[%0d]: got %0d want %0d", k,
                             (k == 0) ? t[0] : t[k] - t[k-1], want);
                end
            end
            checks++;
            if (t[64] - t[0] !== 3472) begin
                errors++;
                $display("FAIL frac_64_ticks: got %0d clocks want 3472", t[64] - t[0]);
            end
        end
    endtask

    task automatic test_div_change();
        int last, t[$];
        clear_run(9, 0);
        last = -1;
        for (int i = 1; i <= 20 && last < 0; i++) begin
            edge_step();
            if (bus.os_tick === 1'b1) last = cyc;
        end
        repeat (3) edge_step();
        bus.div_int = IB'(4);
        for (int i = 0; i < 40 && t.size() < 3; i++) begin
            edge_step();
            if (bus.os_tick === 1'b1) t.push_back(cyc);
        end
        checks++;
        if (last < 0 || t.size() < 3) begin
            errors++;
            $display("FAIL divchg_ticks: got %0d ticks, want 3", t.size());
        end else begin
            checks++;
            if (t[0] - last !== 10) begin
                errors++;
                $display("FAIL divchg_current: got %0d want 10", t[0] - last);
            end
            checks++;
            if (t[1] - t[0] !== 5 || t[2] - t[1] !== 5) begin
                errors++;
                $display("FAIL divchg_new: got %0d,%0d want 5,5", t[1] - t[0], t[2] - t[1]);
            end
        end
    endtask

    task automatic test_sync();
        bit found;
        int first, ticks;
        clear_run(9, 0);
        found = 0;
        for (int i = 0; i < 100 && !found; i++) begin
            edge_step();
            if (bus.os_tick === 1'b1 && bus.os_phase === 4'd5) found = 1;
        end
        repeat (6) edge_step();
        bus.sync = 1'b1;
        edge_step();
        bus.sync = 1'b0;
        checks++;
        if (!found || {bus.os_tick, bus.mid_tick, bus.bit_tick} !== 3'b000 || bus.os_phase !== 4'd0) begin
            errors++;
            $display("FAIL sync_rephase: found=%0d strobes=%b phase=%0d, want 000 phase 0",
                     found, {bus.os_tick, bus.mid_tick, bus.bit_tick}, bus.os_phase);
        end
        first = -1;
        for (int i = 1; i <= 30 && first < 0; i++) begin
            edge_step();
            if (bus.os_tick === 1'b1) first = i;
        end
        checks++;
        if (first !== 10) begin
            errors++;
            $display("FAIL sync_next_tick: got %0d want 10", first);
        end
        repeat (9) edge_step();
        bus.sync = 1'b1;
        edge_step();
        checks++;
        if (bus.os_tick !== 1'b0) begin
            errors++;
            $display("FAIL sync_terminal: os_tick=%b want 0", bus.os_tick);
        end
        ticks = 0;
        for (int i = 0; i < 30; i++) begin
            edge_step();
            if (bus.os_tick !== 1'b0 || bus.os_phase !== 4'd0) ticks++;
        end
        bus.sync = 1'b0;
        checks++;
        if (ticks !== 0) begin
            errors++;
            $display("FAIL sync_held: %0d non-cleared cycles, want 0", ticks);
        end
    endtask

    task automatic test_edges();
        int lows, last, k, want;
        clear_run(0, 0);
        lows = 0;
        for (int i = 0; i < 20; i++) begin
            edge_step();
            if (bus.os_tick !== 1'b1) lows++;
        end
        checks++;
        if (lows !== 0) begin
            errors++;
            $display("FAIL div0_const: %0d low cycles, want 0", lows);
        end
        clear_run(0, 8);
        last = 0; k = 0;
        for (int i = 1; i <= 21; i++) begin
            edge_step();
            if (bus.os_tick === 1'b1) begin
                want = (k == 0) ? 1 : ((k % 2 == 1) ? 1 : 2);
                checks++;
                if (i - last !== want) begin
                    errors++;
                    $display("FAIL div0_frac8[%0d]: got %0d want %0d", k, i - last, want);
                end
                last = i; k++;
            end
        end
        checks++;
        if (k < 10) begin
            errors++;
            $display("FAIL div0_frac8_count: got %0d ticks want >=10", k);
        end
        clear_run(9, 0);
        repeat (14) edge_step();
        bus.en = 1'b0;
        for (int i = 0; i < 12; i++) begin
            edge_step();
            checks++;
            if ({bus.os_tick, bus.mid_tick, bus.bit_tick} !== 3'b000 || bus.os_phase !== 4'd0) begin
                errors++;
                $display("FAIL en_low[%0d]: strobes=%b phase=%0d want 000 phase 0",
                         i, {bus.os_tick, bus.mid_tick, bus.bit_tick}, bus.os_phase);
            end
        end
    endtask

    task automatic test_random();
        clear_run(int'($urandom_range(0, 12)), int'($urandom_range(0, 15)));
        for (int i = 0; i < 3000; i++) begin
            reset    = ($urandom_range(0, 199) != 0);
            bus.en   = ($urandom_range(0, 99) != 0);
            bus.sync = ($urandom_range(0, 79) == 0);
            if ($urandom_range(0, 29) == 0) begin
                bus.div_int  = IB'($urandom_range(0, 12));
                bus.div_frac = FB'($urandom_range(0, 15));
            end
            edge_step();
            checks++;
            if ({bus.os_tick, bus.mid_tick, bus.bit_tick} !== {exp_os, exp_mid, exp_bt} ||
                bus.os_phase !== 4'(m_phase)) begin
                errors++;
                $display("FAIL rand_ovs16@%0d: os/mid/bit=%b phase=%0d want %b phase %0d", i,
                         {bus.os_tick, bus.mid_tick, bus.bit_tick}, bus.os_phase,
                         {exp_os, exp_mid, exp_bt}, m_phase);
            end
            checks++;
            if ({bus2.os_tick, bus2.mid_tick, bus2.bit_tick} !== {exp_os, exp_mid2, exp_bt2} ||
                bus2.os_phase !== 1'(m_phase2)) begin
                errors++;
                $display("FAIL rand_ovs2@%0d: os/mid/bit=%b phase=%0d want %b phase %0d", i,
                         {bus2.os_tick, bus2.mid_tick, bus2.bit_tick}, bus2.os_phase,
                         {exp_os, exp_mid2, exp_bt2}, m_phase2);
            end
        end
        reset = 1'b1;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        cyc    = 0;
        reset  = 1'b0;
        drive(1'b0, 1'b0, 0, 0);
        test_reset();
        test_integer();
        test_fractional();
        test_div_change();
        test_sync();
        test_edges();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
